plic_irq_gateway: RTL and testbench

Per-source interrupt gateway between the platform interrupt producers (PBUS GPIO-in, Timer 0/1, UART) and the PLIC core. It maps raw interrupt lines onto the fixed 32-line PLIC numbering: line 0 is reserved, GPIO-in is line 1, TIM0 line 2, TIM1 line 3, UART line 4. Each line gets a level- or edge-triggered gateway that raises a pending request, blocks re-requests while the interrupt is claimed, and re-arms on completion. The PLIC core consumes `pending_o` and returns claim/complete notifications.

---
 rtl/plic_irq_gateway.sv | 168 ++++++++++++++++
 tb/tb_plic_irq_gateway.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_irq_gateway.sv
// Per-source PLIC interrupt gateways: level or edge triggered, claim/complete gated.
// Optional feature macro PLIC_GATEWAY_SYNC_EN adds a 2-flop input synchronizer.
module plic_irq_gateway #(
    parameter int                     NUM_SOURCES    = 32,
    parameter logic [NUM_SOURCES-1:0] EDGE_MASK      = 'h0000_0006,
    parameter int                     MAX_EDGE_COUNT = 3
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic [NUM_SOURCES-1:0]         irq_src_i,
    input  logic                           claim_valid_i,
    input  logic [$clog2(NUM_SOURCES)-1:0] claim_id_i,
    input  logic                           complete_valid_i,
    input  logic [$clog2(NUM_SOURCES)-1:0] complete_id_i,
    output logic [NUM_SOURCES-1:0]         pending_o,
    output logic [NUM_SOURCES-1:0]         claimed_o
);

    localparam int IDW = $clog2(NUM_SOURCES);
    localparam int CW  = $clog2(MAX_EDGE_COUNT + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_EDGE_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        CLAIMED = 2'd2
    } gw_state_e;

    logic [NUM_SOURCES-1:0] src_w;

`ifdef PLIC_GATEWAY_SYNC_EN
    logic [NUM_SOURCES-1:0] sync1_q;
    logic [NUM_SOURCES-1:0] sync2_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src_i;
            sync2_q <= sync1_q;
        end
    end

    assign src_w = sync2_q;
`else
    assign src_w = irq_src_i;
`endif

    // Line 0 is reserved: its input is dropped and its outputs tied low.
    logic unused_src0;
    assign unused_src0  = src_w[0];
    assign pending_o[0] = 1'b0;
    assign claimed_o[0] = 1'b0;

    for (genvar n = 1; n < NUM_SOURCES; n++) begin : g_src
        localparam logic [IDW-1:0] ID = IDW'(n);

        gw_state_e state_q;
        logic      pend_q;
        logic      clm_q;
        logic      claim_hit;
        logic      comp_hit;

        assign claim_hit    = claim_valid_i && (claim_id_i == ID);
        assign comp_hit     = complete_valid_i && (complete_id_i == ID);
        assign pending_o[n] = pend_q;
        assign claimed_o[n] = clm_q;

        if (EDGE_MASK[n]) begin : g_edge
            logic          prev_q;
            logic [CW-1:0] cnt_q;
            logic          edge_w;

            assign edge_w = src_w[n] & ~prev_q;

            always_ff @(posedge clock_i or posedge reset_i) begin
                if (reset_i) begin
                    state_q <= IDLE;
                    pend_q  <= 1'b0;
                    clm_q   <= 1'b0;
                    prev_q  <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    prev_q <= src_w[n];
                    unique case (state_q)
                        IDLE: begin
                            if (edge_w) begin
                                state_q <= PENDING;
                                pend_q  <= 1'b1;
                            end
                        end
                        PENDING: begin
                            if (claim_hit) begin
                                state_q <= CLAIMED;
                                pend_q  <= 1'b0;
                                clm_q   <= 1'b1;
                            end
                            if (edge_w && cnt_q != MAXC)
                                cnt_q <= cnt_q + CW'(1);
                        end
                        CLAIMED: begin
                            if (comp_hit) begin
                                clm_q <= 1'b0;
                                // A queued edge re-requests; a fresh edge
                                // at cnt==0 becomes the new request itself.
                                if (cnt_q != '0) begin
                                    state_q <= PENDING;
                                    pend_q  <= 1'b1;
                                    if (!edge_w)
                                        cnt_q <= cnt_q - CW'(1);
                                end else if (edge_w) begin
                                    state_q <= PENDING;
                                    pend_q  <= 1'b1;
                                end else begin
                                    state_q <= IDLE;
                                end
                            end else if (edge_w && cnt_q != MAXC) begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                        default: begin
                            state_q <= IDLE;
                            pend_q  <= 1'b0;
                            clm_q   <= 1'b0;
                        end
                    endcase
                end
            end
        end else begin : g_level
            always_ff @(posedge clock_i or posedge reset_i) begin
                if (reset_i) begin
                    state_q <= IDLE;
                    pend_q  <= 1'b0;
                    clm_q   <= 1'b0;
                end else begin
                    unique case (state_q)
                        IDLE: begin
                            if (src_w[n]) begin
                                state_q <= PENDING;
                                pend_q  <= 1'b1;
                            end
                        end
                        PENDING: begin
                            if (claim_hit) begin
                                state_q <= CLAIMED;
                                pend_q  <= 1'b0;
                                clm_q   <= 1'b1;
                            end
                        end
                        CLAIMED: begin
                            if (comp_hit) begin
                                state_q <= IDLE;
                                clm_q   <= 1'b0;
                            end
                        end
                        default: begin
                            state_q <= IDLE;
                            pend_q  <= 1'b0;
                            clm_q   <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_plic_irq_gateway.sv
// Scoreboard bench for plic_irq_gateway: directed test-plan sequences
// followed by random traffic, checked against a behavioural model.
module tb_plic_irq_gateway;

    localparam int N    = 32;
    localparam int MAXC = 3;
`ifdef PLIC_GATEWAY_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic [31:0] irq_src_i;
    logic        claim_valid_i;
    logic [4:0]  claim_id_i;
    logic        complete_valid_i;
    logic [4:0]  complete_id_i;
    logic [31:0] pending_o;
    logic [31:0] claimed_o;

    always #5 clock_i = ~clock_i;

    plic_irq_gateway dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .irq_src_i        (irq_src_i),
        .claim_valid_i    (claim_valid_i),
        .claim_id_i       (claim_id_i),
        .complete_valid_i (complete_valid_i),
        .complete_id_i    (complete_id_i),
        .pending_o        (pending_o),
        .claimed_o        (claimed_o)
    );

    logic [31:0] edge_mask = 32'h0000_0006;
    bit          pend_m[N];
    bit          clm_m[N];
    bit          prev_m[N];
    int          qcnt[N];
    logic [31:0] h1_m;
    logic [31:0] h2_m;
    logic [63:0] sb[$];
    logic [31:0] src_v;
    int          checks  = 0;
    int          errors  = 0;
    bit          started = 0;

    function automatic void model_clear();
        for (int n = 0; n < N; n++) begin
            pend_m[n] = 0;
            clm_m[n]  = 0;
            prev_m[n] = 0;
            qcnt[n]   = 0;
        end
        h1_m = '0;
        h2_m = '0;
    endfunction

    function automatic void model_step(logic [31:0] raw, bit cv, int cid,
                                       bit pv, int pid);
        logic [31:0] samp;
        bit was_idle;
        bit is_edge;
        bit ev;
        bit used;
`ifdef PLIC_GATEWAY_SYNC_EN
        samp = h2_m;
        h2_m = h1_m;
        h1_m = raw;
`else
        samp = raw;
`endif
        for (int n = 1; n < N; n++) begin
            was_idle = !pend_m[n] && !clm_m[n];
            is_edge  = edge_mask[n];
            ev       = is_edge ? (samp[n] && !prev_m[n]) : samp[n];
            used     = 0;
            if (is_edge) prev_m[n] = samp[n];
            if (cv && cid == n && pend_m[n]) begin
                pend_m[n] = 0;
                clm_m[n]  = 1;
            end else if (pv && pid == n && clm_m[n]) begin
                clm_m[n] = 0;
                if (qcnt[n] > 0) begin
                    qcnt[n]   = qcnt[n] - 1;
                    pend_m[n] = 1;
                end else if (is_edge && ev) begin
                    pend_m[n] = 1;
                    used      = 1;
                end
            end
            if (ev && !used) begin
                if (was_idle) pend_m[n] = 1;
                else if (is_edge && qcnt[n] < MAXC) qcnt[n] = qcnt[n] + 1;
            end
        end
    endfunction

    function automatic logic [63:0] model_out();
        logic [31:0] p;
        logic [31:0] c;
        p = '0;
        c = '0;
        for (int n = 1; n < N; n++) begin
            p[n] = pend_m[n];
            c[n] = clm_m[n];
        end
        return {c, p};
    endfunction

    // Called at posedge+1; drives one cycle and queues the response.
    task automatic step(bit cv, int cid, bit pv, int pid);
        irq_src_i        = src_v;
        claim_valid_i    = cv;
        claim_id_i       = 5'(cid);
        complete_valid_i = pv;
        complete_id_i    = 5'(pid);
        model_step(src_v, cv, cid, pv, pid);
        sb.push_back(model_out());
        @(posedge clock_i);
        #1;
    endtask

    task automatic idle(int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0);
    endtask

    task automatic pulse(int n);
        src_v[n] = 1'b1;
        step(0, 0, 0, 0);
        src_v[n] = 1'b0;
        idle(1 + LAT);
    endtask

    // Asserts reset in the middle of the current cycle.
    task automatic mid_reset();
        sb.delete();
        sb.push_back(64'd0);
        #2;
        reset_i = 1'b1;
        model_clear();
        @(posedge clock_i);
        #1;
        sb.push_back(64'd0);
        reset_i = 1'b0;
    endtask

    always @(negedge clock_i) begin
        logic [63:0] exp_v;
        if (started) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow t=%0t", $time);
            end else begin
                exp_v = sb.pop_front();
                checks++;
                if (pending_o !== exp_v[31:0]) begin
                    errors++;
                    $display("FAIL pending_o actual=%h expected=%h t=%0t",
                             pending_o, exp_v[31:0], $time);
                end
                checks++;
                if (claimed_o !== exp_v[63:32]) begin
                    errors++;
                    $display("FAIL claimed_o actual=%h expected=%h t=%0t",
                             claimed_o, exp_v[63:32], $time);
                end
            end
        end
    end

    initial begin
        reset_i          = 1'b1;
        src_v            = '0;
        irq_src_i        = '0;
        claim_valid_i    = 1'b0;
        claim_id_i       = '0;
        complete_valid_i = 1'b0;
        complete_id_i    = '0;
        model_clear();
        @(posedge clock_i);
        #1;
        sb.push_back(64'd0);
        started = 1;
        @(posedge clock_i);
        #1;
        sb.push_back(64'd0);
        reset_i = 1'b0;

        // Reserved line 0 is driven high for the whole run.
        src_v[0] = 1'b1;

        // Level source 4: pend, claim, complete with input still high.
        src_v[4] = 1'b1;
        idle(1 + LAT);
        step(1, 4, 0, 0);
        idle(1);
        step(0, 0, 1, 4);
        idle(2);
        step(1, 4, 0, 0);
        idle(1);

        // Edge source 2: claim, 5 pulses while claimed, then drain.
        pulse(2);
        step(1, 2, 0, 0);
        for (int i = 0; i < 5; i++) pulse(2);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 2);
            step(1, 2, 0, 0);
        end
        step(0, 0, 1, 2);
        idle(2);

        // Ignored claim/complete requests.
        src_v[1] = 1'b1;
        idle(1 + LAT);
        step(1, 3, 0, 0);
        step(0, 0, 1, 1);
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        idle(1);

        // Claim 2 and complete 4 in the same cycle.
        pulse(2);
        step(1, 2, 1, 4);
        idle(1);
        // Edge on 2 coincident with its complete at cnt==0.
        src_v[2] = 1'b1;
        idle(LAT);
        step(0, 0, 1, 2);
        src_v[2] = 1'b0;
        idle(2);

        // Mixed states, then asynchronous reset mid-cycle.
        step(1, 1, 0, 0);
        pulse(3);
        step(1, 2, 0, 0);
        idle(1);
        mid_reset();
        idle(4);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            int cid;
            int pid;
            if ((i % 4) == 0)
                src_v = $urandom() & 32'h0000_00FF;
            if ($urandom_range(0, 3) == 0)
                src_v[$urandom_range(2, 3)] = ~src_v[$urandom_range(2, 3)];
            cid = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7)
                                               : $urandom_range(0, 31);
            pid = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7)
                                               : $urandom_range(0, 31);
            step($urandom_range(0, 1) == 1, cid,
                 $urandom_range(0, 1) == 1, pid);
            if (i == 300) mid_reset();
        end

        src_v = '0;
        idle(4);
        #6;
        started = 0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover actual=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
